// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared FSM state type, gain constant and saturation helper for the mixer
package audio_mixer_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} mixer_state_t;
  localparam int DEFAULT_VOLUME_BITS = 8;
  localparam int UNITY_GAIN = 1 << (DEFAULT_VOLUME_BITS - 1);
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/audio_mixer_n_ram.sv
// mixer_sample_ram: circular sample store with one write port and a registered read port (old data on collision)
import audio_mixer_pkg::*;
module mixer_sample_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write port plus registered read; reset clears every slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/audio_mixer_n.sv
// audio_mixer_n: N-channel gain mixer writing LAG slots behind the I2S read index; AUDIO_MIXER_PEAK_EN adds a peak output
import audio_mixer_pkg::*;
module audio_mixer_n #(
  parameter int NUM_CH = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN = 32,
  parameter int LAG = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*SAMPLE_BITS-1:0] ch_sample,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*VOLUME_BITS-1:0] ch_volume,
  input  logic [VOLUME_BITS-1:0]        master_volume,
  input  logic [$clog2(BUF_LEN)-1:0]    rd_index,
  output logic [SAMPLE_BITS-1:0]        rd_sample,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun,
  input  logic                          status_clr
`ifdef AUDIO_MIXER_PEAK_EN
  , output logic [SAMPLE_BITS-2:0]      peak
`endif
);
  localparam int IW = $clog2(BUF_LEN);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = SAMPLE_BITS + 2 + $clog2(NUM_CH);
  localparam int SH = VOLUME_BITS - 1;
  mixer_state_t state;
  logic [IW-1:0] prev_index, wr_addr;
  logic signed [SAMPLE_BITS-1:0] s_snap [NUM_CH];
  logic [VOLUME_BITS-1:0] v_snap [NUM_CH];
  logic [NUM_CH-1:0] ok_snap;
  logic [VOLUME_BITS-1:0] mv_snap;
  logic [CW-1:0] ch_idx;
  logic signed [AW-1:0] acc, term;
  logic signed [SAMPLE_BITS+VOLUME_BITS:0] prod;
  logic signed [AW+VOLUME_BITS:0] mprod;
  logic signed [63:0] scaled, sat;
  logic signed [SAMPLE_BITS-1:0] sat_q;
  logic trig;
  // index-change detect, shared per-channel multiplier, and master gain with saturation
  always_comb begin
    trig = rd_index != prev_index;
    prod = s_snap[ch_idx] * $signed({1'b0, v_snap[ch_idx]});
    term = ok_snap[ch_idx] ? AW'(prod >>> SH) : '0;
    mprod = acc * $signed({1'b0, mv_snap});
    scaled = 64'(mprod >>> SH);
    sat = saturate(scaled, SAMPLE_BITS);
  end
  // mix sequencer: snapshot on trigger, accumulate one channel per cycle, scale, write back; sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_index <= '0;
      wr_addr <= '0;
      acc <= '0;
      ch_idx <= '0;
      sat_q <= '0;
      ok_snap <= '0;
      mv_snap <= '0;
      busy <= 1'b0;
      clip <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev_index <= rd_index;
      overrun <= (trig && state != IDLE) || (overrun && !status_clr);
      clip <= (state == SCALE && sat != scaled) || (clip && !status_clr);
      case (state)
        IDLE: if (trig) begin
          for (int k = 0; k < NUM_CH; k++) begin
            s_snap[k] <= ch_sample[k*SAMPLE_BITS +: SAMPLE_BITS];
            v_snap[k] <= ch_volume[k*VOLUME_BITS +: VOLUME_BITS];
          end
          ok_snap <= ch_valid;
          mv_snap <= master_volume;
          wr_addr <= rd_index - IW'(LAG);
          acc <= '0;
          ch_idx <= '0;
          busy <= 1'b1;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + term;
          ch_idx <= ch_idx + 1'b1;
          if (ch_idx == CW'(NUM_CH - 1)) state <= SCALE;
        end
        SCALE: begin
          sat_q <= SAMPLE_BITS'(sat);
          state <= WRITE;
        end
        WRITE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  mixer_sample_ram #(.DEPTH(BUF_LEN), .WIDTH(SAMPLE_BITS)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(state == WRITE),
    .waddr(wr_addr),
    .wdata(sat_q),
    .raddr(rd_index),
    .rdata(rd_sample)
  );
`ifdef AUDIO_MIXER_PEAK_EN
  logic [SAMPLE_BITS-2:0] mag, peak_base;
  logic signed [SAMPLE_BITS-1:0] neg;
  // magnitude of the sample being written, most negative code clamped to full scale
  always_comb begin
    neg = -sat_q;
    mag = sat_q[SAMPLE_BITS-1] ? (neg[SAMPLE_BITS-1] ? '1 : neg[SAMPLE_BITS-2:0]) : sat_q[SAMPLE_BITS-2:0];
    peak_base = status_clr ? '0 : peak;
  end
  // peak hold; a write in the clearing cycle still registers its magnitude
  always_ff @(posedge clk) peak <= rst ? '0 : (state == WRITE && mag > peak_base) ? mag : peak_base;
`endif
endmodule

// File: tb/tb_audio_mixer_n.sv
// tb_audio_mixer_n: randomized and directed scoreboard bench for audio_mixer_n
module tb_audio_mixer_n;
  localparam int N = 4;
  localparam int SB = 16;
  localparam int VB = 8;
  localparam int BL = 32;
  localparam int LAG = 10;
  localparam int IW = 5;
  localparam int FS = 32767;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*SB-1:0] ch_sample = '0;
  logic [N-1:0] ch_valid = '0;
  logic [N*VB-1:0] ch_volume = '0;
  logic [VB-1:0] master_volume = '0;
  logic [IW-1:0] rd_index = '0;
  logic status_clr = 1'b0;
  logic [SB-1:0] rd_sample;
  logic busy, clip, overrun;
`ifdef AUDIO_MIXER_PEAK_EN
  logic [SB-2:0] peak;
`endif

  audio_mixer_n #(.NUM_CH(N), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BL), .LAG(LAG)) dut (
    .clk(clk),
    .rst(rst),
    .ch_sample(ch_sample),
    .ch_valid(ch_valid),
    .ch_volume(ch_volume),
    .master_volume(master_volume),
    .rd_index(rd_index),
    .rd_sample(rd_sample),
    .busy(busy),
    .clip(clip),
    .overrun(overrun),
    .status_clr(status_clr)
`ifdef AUDIO_MIXER_PEAK_EN
    , .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int val;} wr_t;
  wr_t q[$];
  int mem_model [BL] = '{default: 0};
  int s_m [N];
  int v_m [N];
  logic [N-1:0] ok_m;
  int mv_m;
  bit clip_exp, ov_exp;
  int peak_exp;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a);
    longint d;
    d = 1 << (VB - 1);
    return a >= 0 ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic longint mix_raw();
    longint acc;
    acc = 0;
    for (int k = 0; k < N; k++) if (ok_m[k]) acc += fdiv(longint'(s_m[k]) * v_m[k]);
    return fdiv(acc * mv_m);
  endfunction

  function automatic int rs();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic set_ch(input int s0, s1, s2, s3, input logic [3:0] ok, input int v0, v1, v2, v3, input int mv);
    s_m = '{s0, s1, s2, s3};
    v_m = '{v0, v1, v2, v3};
    ok_m = ok;
    mv_m = mv;
    for (int k = 0; k < N; k++) begin
      ch_sample[k*SB +: SB] = SB'(s_m[k]);
      ch_volume[k*VB +: VB] = VB'(v_m[k]);
    end
    ch_valid = ok;
    master_volume = VB'(mv);
  endtask

  task automatic push_mix(input int idx);
    longint m;
    wr_t it;
    int mag;
    m = mix_raw();
    it.val = m > FS ? FS : (m < -FS - 1 ? -FS - 1 : int'(m));
    if (longint'(it.val) != m) clip_exp = 1;
    it.addr = (idx - LAG + BL) % BL;
    mag = it.val < 0 ? (it.val == -FS - 1 ? FS : -it.val) : it.val;
    if (mag > peak_exp) peak_exp = mag;
    q.push_back(it);
  endtask

  task automatic check_flags();
    chk("busy_idle", busy, 0);
    chk("clip", clip, clip_exp);
    chk("overrun", overrun, ov_exp);
`ifdef AUDIO_MIXER_PEAK_EN
    chk("peak", peak, peak_exp);
`endif
  endtask

  task automatic step(input int idx, input bit chk_rd, input int exp_rd);
    push_mix(idx);
    rd_index = IW'(idx);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    if (chk_rd) chk($sformatf("rd_sample[%0d]", idx), $signed(rd_sample), exp_rd);
    repeat (N + 2) @(posedge clk);
    @(negedge clk);
    check_flags();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_status();
    status_clr = 1'b1;
    @(posedge clk);
    #1;
    status_clr = 1'b0;
    clip_exp = 0;
    ov_exp = 0;
    peak_exp = 0;
    @(negedge clk);
    chk("clip_cleared", clip, 0);
    chk("overrun_cleared", overrun, 0);
    @(posedge clk);
    #1;
  endtask

  // monitor: each completed mix retires one expected write; stable read index must show the model slot
  int prev_idx = 0;
  bit prev_busy = 0;
  bit prev_ok = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < BL; i++) mem_model[i] = 0;
    end else begin
      if (prev_ok && int'(rd_index) == prev_idx) chk("rd_port", $signed(rd_sample), mem_model[rd_index]);
      if (prev_busy && !busy) begin
        if (q.size() == 0) chk("spurious_write", 1, 0);
        else begin
          wr_t it;
          it = q.pop_front();
          mem_model[it.addr] = it.val;
        end
      end
    end
    prev_idx = int'(rd_index);
    prev_busy = busy;
    prev_ok = !rst;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int idx;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rd_sample", rd_sample, 0);
    check_flags();
    @(posedge clk);
    #1;

    set_ch(1000, 2000, -500, 0, 4'b1111, 128, 128, 128, 128, 128);
    step(12, 0, 0);
    step(13, 0, 0);
    set_ch(0, 0, 0, 0, 4'b0000, 128, 128, 128, 128, 128);
    step(3, 1, 2500);

    set_ch(30000, 30000, 0, 0, 4'b0011, 128, 128, 128, 128, 128);
    step(4, 0, 0);
    chk("clip_after_pos_sat", clip, 1);
    set_ch(-30000, -30000, 0, 0, 4'b0011, 128, 128, 128, 128, 128);
    step(5, 0, 0);
    set_ch(0, 0, 0, 0, 4'b0000, 128, 128, 128, 128, 128);
    step(26, 1, 32767);
    step(27, 1, -32768);
`ifdef AUDIO_MIXER_PEAK_EN
    chk("peak_after_sat", peak, 32767);
`endif
    clear_status();

    set_ch(100, 200, 300, 400, 4'b0101, 255, 128, 128, 128, 64);
    step(0, 0, 0);
    step(1, 0, 0);
    set_ch(0, 0, 0, 0, 4'b0000, 128, 128, 128, 128, 128);
    step(23, 1, 249);

    set_ch(1234, -321, 50, 7, 4'b1111, 100, 200, 30, 128, 128);
    push_mix(6);
    rd_index = IW'(6);
    repeat (2) @(posedge clk);
    #1;
    rd_index = IW'(7);
    ov_exp = 1;
    repeat (N + 2) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    check_flags();
    @(posedge clk);
    #1;
    clear_status();

    set_ch(5000, 6000, 7000, 8000, 4'b1111, 128, 128, 128, 128, 128);
    push_mix(8);
    rd_index = IW'(8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_index = '0;
    clip_exp = 0;
    ov_exp = 0;
    peak_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_sample", rd_sample, 0);
    check_flags();
    repeat (N + 3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_resume", busy, 0);
    @(posedge clk);
    #1;
    set_ch(0, 0, 0, 0, 4'b0000, 128, 128, 128, 128, 128);
    step(30, 1, 0);

    idx = 30;
    for (int i = 0; i < 60; i++) begin
      idx = (idx + 1) % BL;
      set_ch(rs(), rs(), rs(), rs(), 4'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if (i % 20 == 19) clear_status();
      step(idx, 0, 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
